// File: rtl/twiddle_mult_stage.sv
// Complex twiddle multiplier: three-stage pipeline with valid/ready flow control.
// Coefficients are selected by a per-frame sample index that restarts on in_last.
module twiddle_mult_stage #(
    parameter int NBITS = 11,
    parameter int N     = 32,
    localparam int IW   = (N > 1) ? $clog2(N) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NBITS*N*2-1:0]      coeff_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [NBITS-1:0]   in_re,
    input  logic signed [NBITS-1:0]   in_im,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [NBITS-1:0]   out_re,
    output logic signed [NBITS-1:0]   out_im,
    output logic                      out_last,
    output logic [IW-1:0]             out_index
);

    localparam int PW = 2 * NBITS;
    localparam logic signed [PW:0] RND     = {{(NBITS+3){1'b0}}, 1'b1, {(NBITS-3){1'b0}}};
    localparam logic signed [PW:0] SAT_MAX = {{(NBITS+2){1'b0}}, {(NBITS-1){1'b1}}};
    localparam logic signed [PW:0] SAT_MIN = {{(NBITS+2){1'b1}}, {(NBITS-1){1'b0}}};

    logic signed [NBITS-1:0] coef_re [N];
    logic signed [NBITS-1:0] coef_im [N];

    // Entry 0 sits in the most significant slot of the packed bus.
    for (genvar gi = 0; gi < N; gi++) begin : g_coef
        assign coef_re[gi] = coeff_data[2*NBITS*(N-gi)-1 -: NBITS];
        assign coef_im[gi] = coeff_data[2*NBITS*(N-gi)-NBITS-1 -: NBITS];
    end

    logic                    en;
    logic                    xfer;
    logic [IW-1:0]           idx_q, idx_d;

    logic                    v1_q, v2_q, v3_q;
    logic signed [NBITS-1:0] a_q, b_q, c_q, d_q;
    logic                    last1_q, last2_q, last3_q;
    logic [IW-1:0]           idx1_q, idx2_q, idx3_q;
    logic signed [PW-1:0]    ac_q, bd_q, ad_q, bc_q;
    logic signed [PW-1:0]    ac_d, bd_d, ad_d, bc_d;
    logic signed [PW:0]      re_full_d, im_full_d;
    logic signed [NBITS-1:0] re_d, im_d;
    logic signed [NBITS-1:0] re_q, im_q;

    function automatic logic signed [NBITS-1:0] round_sat(input logic signed [PW:0] v);
        logic signed [PW:0] s;
        s = (v + RND) >>> (NBITS - 2);
        if (s > SAT_MAX)
            round_sat = SAT_MAX[NBITS-1:0];
        else if (s < SAT_MIN)
            round_sat = SAT_MIN[NBITS-1:0];
        else
            round_sat = s[NBITS-1:0];
    endfunction

    assign en        = !v3_q || out_ready;
    assign in_ready  = en;
    assign xfer      = in_valid && en;
    assign out_valid = v3_q;
    assign out_re    = re_q;
    assign out_im    = im_q;
    assign out_last  = last3_q;
    assign out_index = idx3_q;

    always_comb begin
        idx_d = idx_q;
        if (xfer) begin
            if (in_last || idx_q == IW'(N - 1))
                idx_d = '0;
            else
                idx_d = idx_q + IW'(1);
        end
    end

    always_comb begin
        ac_d      = PW'(a_q) * PW'(c_q);
        bd_d      = PW'(b_q) * PW'(d_q);
        ad_d      = PW'(a_q) * PW'(d_q);
        bc_d      = PW'(b_q) * PW'(c_q);
        re_full_d = (PW+1)'(ac_q) - (PW+1)'(bd_q);
        im_full_d = (PW+1)'(ad_q) + (PW+1)'(bc_q);
        re_d      = round_sat(re_full_d);
        im_d      = round_sat(im_full_d);
    end

    // Every stage, valid bit and the index counter freeze together when en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            last1_q <= 1'b0;
            last2_q <= 1'b0;
            last3_q <= 1'b0;
            idx1_q  <= '0;
            idx2_q  <= '0;
            idx3_q  <= '0;
            ac_q    <= '0;
            bd_q    <= '0;
            ad_q    <= '0;
            bc_q    <= '0;
            re_q    <= '0;
            im_q    <= '0;
        end else if (en) begin
            idx_q   <= idx_d;
            v1_q    <= xfer;
            a_q     <= in_re;
            b_q     <= in_im;
            c_q     <= coef_re[idx_q];
            d_q     <= coef_im[idx_q];
            last1_q <= in_last;
            idx1_q  <= idx_q;

            v2_q    <= v1_q;
            ac_q    <= ac_d;
            bd_q    <= bd_d;
            ad_q    <= ad_d;
            bc_q    <= bc_d;
            last2_q <= last1_q;
            idx2_q  <= idx1_q;

            v3_q    <= v2_q;
            re_q    <= re_d;
            im_q    <= im_d;
            last3_q <= last2_q;
            idx3_q  <= idx2_q;
        end
    end

endmodule

// File: tb/tb_twiddle_mult_stage.sv
// Scoreboard bench for twiddle_mult_stage: a reference model queues expected
// outputs at each input transfer; a monitor pops and compares on each output transfer.
module tb_twiddle_mult_stage;

    localparam int NB = 11;
    localparam int N  = 32;
    localparam int IW = $clog2(N);

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NB*N*2-1:0]      coeff_data;
    logic                   in_valid;
    logic                   in_ready;
    logic signed [NB-1:0]   in_re, in_im;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic signed [NB-1:0]   out_re, out_im;
    logic                   out_last;
    logic [IW-1:0]          out_index;

    twiddle_mult_stage #(.NBITS(NB), .N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .coeff_data (coeff_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_last   (out_last),
        .out_index  (out_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        int re;
        int im;
        int idx;
        int last;
    } exp_t;

    exp_t sb[$];
    int   cre [N];
    int   cim [N];
    int   model_idx;
    int   n_checks = 0;
    int   n_errors = 0;
    int   pop_cnt, last_cnt, last_seen_idx;
    int   last_re, last_im, last_idx;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Round half up at 2^(NB-3), floor-divide by 2^(NB-2), clamp to NB bits.
    function automatic int round_sat_model(input longint x);
        longint q, y;
        q = x + (longint'(1) <<< (NB - 3));
        if (q >= 0)
            y = q / (longint'(1) <<< (NB - 2));
        else
            y = -((-q + (longint'(1) <<< (NB - 2)) - 1) / (longint'(1) <<< (NB - 2)));
        if (y > (2**(NB-1)) - 1) y = (2**(NB-1)) - 1;
        if (y < -(2**(NB-1)))    y = -(2**(NB-1));
        return int'(y);
    endfunction

    task automatic send(input int re, input int im, input bit last);
        int   n;
        exp_t e;
        #1;
        in_valid = 1'b1;
        in_re    = NB'(re);
        in_im    = NB'(im);
        in_last  = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("send_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        e.re   = round_sat_model(longint'(re) * cre[model_idx] - longint'(im) * cim[model_idx]);
        e.im   = round_sat_model(longint'(re) * cim[model_idx] + longint'(im) * cre[model_idx]);
        e.idx  = model_idx;
        e.last = int'(last);
        sb.push_back(e);
        model_idx = (last || model_idx == N - 1) ? 0 : model_idx + 1;
        @(posedge clk);
    endtask

    task automatic idle();
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain", sb.size(), 0);
        repeat (3) @(posedge clk);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1 rst = 1'b1;
        sb.delete();
        model_idx = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_output", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("out idx=%0d re=%0d im=%0d last=%0d", out_index, out_re, out_im, out_last);
                check("out_re", int'(out_re), e.re);
                check("out_im", int'(out_im), e.im);
                check("out_index", int'(out_index), e.idx);
                check("out_last", int'(out_last), e.last);
                pop_cnt++;
                if (out_last) begin
                    last_cnt++;
                    last_seen_idx = int'(out_index);
                end
                last_re  = int'(out_re);
                last_im  = int'(out_im);
                last_idx = int'(out_index);
            end
        end
    end

    initial begin
        int snap_re, snap_im, snap_idx;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_idx = 0;
        pop_cnt   = 0;
        last_cnt  = 0;
        last_seen_idx = -1;
        for (int k = 0; k < N; k++) begin
            cre[k] = int'($urandom_range(1023)) - 512;
            cim[k] = int'($urandom_range(1023)) - 512;
        end
        cre[0] = 512;  cim[0] = 0;
        cre[9] = 502;  cim[9] = -100;
        coeff_data = '0;
        for (int k = 0; k < N; k++) begin
            coeff_data[2*NB*(N-k)-1 -: NB]    = NB'(cre[k]);
            coeff_data[2*NB*(N-k)-NB-1 -: NB] = NB'(cim[k]);
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_index", int'(out_index), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_re", int'(out_re), 0);
        check("rst_out_im", int'(out_im), 0);
        rst = 1'b0;
        @(posedge clk);

        // Identity and latency
        send(100, 0, 1'b0);
        idle();
        @(negedge clk);
        check("lat_cycle1", int'(out_valid), 0);
        @(negedge clk);
        check("lat_cycle2", int'(out_valid), 0);
        @(negedge clk);
        check("lat_cycle3", int'(out_valid), 1);
        check("id_re", int'(out_re), 100);
        check("id_im", int'(out_im), 0);
        check("id_index", int'(out_index), 0);
        drain();

        // Saturation and rounding at coefficient 9
        reset_dut();
        for (int i = 0; i < 9; i++)
            send(int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024, 1'b0);
        send(1023, 1023, 1'b0);
        idle();
        drain();
        check("sat_re", last_re, 1023);
        check("sat_im", last_im, 803);
        check("sat_index", last_idx, 9);

        // Negative extreme through unity coefficient
        reset_dut();
        send(-1024, -1024, 1'b0);
        idle();
        drain();
        check("neg_re", last_re, -1024);
        check("neg_im", last_im, -1024);

        // Index wrap over 33 continuous samples
        reset_dut();
        for (int i = 0; i < 33; i++)
            send(int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024, 1'b0);
        idle();
        drain();
        check("wrap_index33", last_idx, 0);

        // in_last on sample 5 restarts the index
        reset_dut();
        last_cnt = 0;
        last_seen_idx = -1;
        for (int i = 0; i < 8; i++)
            send(int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024, i == 5);
        idle();
        drain();
        check("last_count", last_cnt, 1);
        check("last_at_index", last_seen_idx, 5);
        check("after_last_index", last_idx, 1);

        // Backpressure with three samples in flight and a fourth waiting
        reset_dut();
        pop_cnt = 0;
        for (int i = 0; i < 3; i++)
            send(int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024, 1'b0);
        #1 out_ready = 1'b0;
        fork
            send(-300, 250, 1'b0);
            begin
                @(negedge clk);
                snap_re  = int'(out_re);
                snap_im  = int'(out_im);
                snap_idx = int'(out_index);
                check("bp_valid", int'(out_valid), 1);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold_valid", int'(out_valid), 1);
                    check("bp_in_ready", int'(in_ready), 0);
                    check("bp_hold_re", int'(out_re), snap_re);
                    check("bp_hold_im", int'(out_im), snap_im);
                    check("bp_hold_index", int'(out_index), snap_idx);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle();
        drain();
        check("bp_count", pop_cnt, 4);

        // Reset with samples in flight
        reset_dut();
        for (int i = 0; i < 7; i++)
            send(int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024, 1'b0);
        idle();
        drain();
        for (int i = 0; i < 3; i++)
            send(int'($urandom_range(2047)) - 1024, int'($urandom_range(2047)) - 1024, 1'b0);
        idle();
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_index", int'(out_index), 7);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", int'(out_valid), 0);
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_index", int'(out_index), 0);
        sb.delete();
        model_idx = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        pop_cnt = 0;
        send(200, -50, 1'b0);
        idle();
        drain();
        check("post_rst_count", pop_cnt, 1);
        check("post_rst_index", last_idx, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
